// File: rtl/riscv_fetch_queue.sv
// Instruction fetch front-end: credit-limited requests to a variable-latency
// instruction memory, in-order return queue, and redirect flush of in-flight responses.
module riscv_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned XLEN     = 32,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned PC_STEP  = 1
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  output logic            busy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [XLEN-1:0] RST_PC  = XLEN'(RESET_PC);
  localparam logic [XLEN-1:0] STEP    = XLEN'(PC_STEP);
  localparam logic [CW:0]     DEPTH_W = (CW+1)'(DEPTH);

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [XLEN-1:0] instr_mem_q [DEPTH];
  logic [XLEN-1:0] pc_mem_q    [DEPTH];

  logic credit_ok, req_fire, rsp_take, rsp_drop, push, pop;

  // Credit covers queued plus in-flight, so every response is guaranteed a slot.
  assign credit_ok = ({1'b0, count_q} + {1'b0, outst_q}) < DEPTH_W;
  assign imem_req_valid = !rst && (state_q == ST_FETCH) && !halt && !redirect_valid && credit_ok;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses with nothing outstanding belong to requests issued before a reset.
  assign rsp_take = imem_rsp_valid && (outst_q != '0);
  assign rsp_drop = rsp_take && ((discard_q != '0) || redirect_valid);
  assign push     = rsp_take && !rsp_drop;

  assign id_valid = (count_q != '0);
  assign id_instr = id_valid ? instr_mem_q[rd_ptr_q] : '0;
  assign id_pc    = id_valid ? pc_mem_q[rd_ptr_q] : '0;
  assign pop      = id_valid && id_ready && !redirect_valid;
  assign busy     = (outst_q != '0) || (discard_q != '0);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    outst_d    = outst_q + CW'(req_fire) - CW'(rsp_take);
    discard_d  = discard_q;
    if (redirect_valid) begin
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      discard_d  = outst_q - CW'(rsp_take);
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      if (discard_d != '0) state_d = ST_FLUSH;
      else if (halt)       state_d = ST_HALT;
      else                 state_d = ST_FETCH;
    end else begin
      count_d   = count_q + CW'(push) - CW'(pop);
      wr_ptr_d  = wr_ptr_q + PW'(push);
      rd_ptr_d  = rd_ptr_q + PW'(pop);
      discard_d = discard_q - CW'(rsp_take && (discard_q != '0));
      if (req_fire) fetch_pc_d = fetch_pc_q + STEP;
      if (push)     resp_pc_d  = resp_pc_q + STEP;
      case (state_q)
        ST_FETCH: if (halt) state_d = ST_HALT;
        ST_FLUSH: if (discard_d == '0) state_d = halt ? ST_HALT : ST_FETCH;
        ST_HALT:  if (!halt) state_d = ST_FETCH;
        default:  state_d = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      fetch_pc_q <= RST_PC;
      resp_pc_q  <= RST_PC;
      count_q    <= '0;
      outst_q    <= '0;
      discard_q  <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Storage needs no reset: id_* are masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      instr_mem_q[wr_ptr_q] <= imem_rsp_data;
      pc_mem_q[wr_ptr_q]    <= resp_pc_q;
    end
  end

endmodule

// File: tb/tb_riscv_fetch_queue.sv
// Bench for riscv_fetch_queue: queue-based reference model plus latency-programmable
// instruction memory, directed scenarios followed by a randomized phase.
module tb_riscv_fetch_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid, id_ready;
  logic [31:0] id_instr, id_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt, busy;

  always #5 clk = ~clk;

  riscv_fetch_queue #(.DEPTH(DEPTH), .XLEN(32), .RESET_PC(0), .PC_STEP(1)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt), .busy(busy)
  );

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  // reference model: queue contents, in-flight/discard counts, mode 0=fetch 1=flush 2=halt
  logic [31:0] q_instr[$];
  logic [31:0] q_pc[$];
  int          m_out, m_disc, m_mode;
  logic [31:0] m_fpc, m_rpc;
  logic        m_rv, m_idv, m_busy;
  logic [31:0] m_instr, m_pc;

  // memory model: responses due in order, one per cycle at most
  int          mq_due[$];
  logic [31:0] mq_addr[$];
  int          last_due = -1;
  int          mem_lat = 1;

  logic        o_fire, o_rv, o_idv, o_busy;
  logic [31:0] o_addr, o_pc, o_instr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic m_reset();
    q_instr.delete();
    q_pc.delete();
    m_out = 0; m_disc = 0; m_mode = 0;
    m_fpc = 32'd0; m_rpc = 32'd0;
  endtask

  task automatic cycle();
    logic acc, rsp;
    int due;
    if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h13 + mq_addr[0];
      void'(mq_due.pop_front());
      void'(mq_addr.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    @(negedge clk);
    m_rv    = !rst && m_mode == 0 && !halt && !redirect_valid && (q_pc.size() + m_out < DEPTH);
    m_idv   = q_pc.size() > 0;
    m_instr = m_idv ? q_instr[0] : 32'd0;
    m_pc    = m_idv ? q_pc[0] : 32'd0;
    m_busy  = (m_out != 0) || (m_disc != 0);
    chk("req_valid", imem_req_valid, m_rv);
    chk("req_addr", imem_req_addr, m_fpc);
    chk("id_valid", id_valid, m_idv);
    chk("id_instr", id_instr, m_instr);
    chk("id_pc", id_pc, m_pc);
    chk("busy", busy, m_busy);
    o_rv = imem_req_valid; o_fire = imem_req_valid && imem_req_ready; o_addr = imem_req_addr;
    o_idv = id_valid; o_pc = id_pc; o_instr = id_instr; o_busy = busy;

    acc = m_rv && imem_req_ready;
    if (acc) begin
      due = cyc + mem_lat;
      if (due <= last_due) due = last_due + 1;
      mq_due.push_back(due);
      mq_addr.push_back(m_fpc);
      last_due = due;
    end
    if (rst) m_reset();
    else begin
      rsp = imem_rsp_valid && m_out > 0;
      if (redirect_valid) begin
        q_instr.delete();
        q_pc.delete();
        if (rsp) m_out--;
        m_disc = m_out;
        m_fpc = redirect_pc;
        m_rpc = redirect_pc;
        m_mode = (m_disc > 0) ? 1 : (halt ? 2 : 0);
      end else begin
        if (m_idv && id_ready) begin
          void'(q_instr.pop_front());
          void'(q_pc.pop_front());
        end
        if (rsp) begin
          m_out--;
          if (m_disc > 0) m_disc--;
          else begin
            q_instr.push_back(imem_rsp_data);
            q_pc.push_back(m_rpc);
            m_rpc = m_rpc + 32'd1;
          end
        end
        if (acc) begin
          m_out++;
          m_fpc = m_fpc + 32'd1;
        end
        if (m_mode == 0 && halt) m_mode = 2;
        else if (m_mode == 1 && m_disc == 0) m_mode = halt ? 2 : 0;
        else if (m_mode == 2 && !halt) m_mode = 0;
      end
      chk("credit_bound", (q_pc.size() + m_out <= DEPTH && m_out >= 0 && m_disc >= 0), 1'b1);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) cycle();
    rst = 1'b0;
  endtask

  initial begin
    int first_v, fires, seen;
    logic found, found2;
    logic [31:0] first_addr, first_pc, first_instr, lastpc;
    rst = 1'b1; imem_req_ready = 1'b0; halt = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'd0; id_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
    m_reset();
    @(posedge clk);
    #1;

    // zero-wait streaming
    imem_req_ready = 1'b1; id_ready = 1'b1; mem_lat = 1;
    do_reset(6);
    chk("rst_req_valid", o_rv, 1'b0);
    first_v = -1;
    for (int k = 0; k < 12; k++) begin
      cycle();
      if (k == 0) begin
        chk("rst_id_valid", o_idv, 1'b0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_req_addr", o_addr, 32'd0);
      end
      if (o_idv && first_v < 0) first_v = k;
      if (k >= 2) begin
        chk("t1_pc", o_pc, 32'(k - 2));
        chk("t1_instr", o_instr, 32'h13 + 32'(k - 2));
      end
    end
    chk("t1_first_valid", 32'(first_v), 32'd2);

    // decode stall until full
    id_ready = 1'b0;
    do_reset(6);
    fires = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (o_fire) fires++;
    end
    chk("t2_accepts", 32'(fires), 32'd4);
    chk("t2_req_valid", o_rv, 1'b0);
    chk("t2_head_valid", o_idv, 1'b1);
    chk("t2_head_pc", o_pc, 32'd0);
    id_ready = 1'b1; seen = 0; found = 1'b0; first_addr = 32'd0;
    for (int k = 0; k < 12; k++) begin
      cycle();
      if (k < 4) begin
        chk("t2_drain_valid", o_idv, 1'b1);
        chk("t2_drain_pc", o_pc, 32'(seen));
        seen++;
      end
      if (o_fire && !found) begin found = 1'b1; first_addr = o_addr; end
    end
    chk("t2_resume_found", found, 1'b1);
    chk("t2_resume_addr", first_addr, 32'd4);

    // redirect with three requests in flight
    mem_lat = 4;
    do_reset(6);
    repeat (3) cycle();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    cycle();
    redirect_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("t3_flush_busy", o_busy, 1'b1);
      chk("t3_flush_idv", o_idv, 1'b0);
      chk("t3_flush_req", o_rv, 1'b0);
    end
    found = 1'b0; found2 = 1'b0; first_addr = 32'd0; first_pc = 32'd0; first_instr = 32'd0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (o_fire && !found) begin found = 1'b1; first_addr = o_addr; end
      if (o_idv && !found2) begin found2 = 1'b1; first_pc = o_pc; first_instr = o_instr; end
    end
    chk("t3_refetch_found", found && found2, 1'b1);
    chk("t3_refetch_addr", first_addr, 32'h40);
    chk("t3_first_pc", first_pc, 32'h40);
    chk("t3_first_instr", first_instr, 32'h53);

    // redirect coinciding with a response and a pop
    mem_lat = 2;
    do_reset(6);
    repeat (6) cycle();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    chk("t4_empty", o_idv, 1'b0);
    chk("t4_busy", o_busy, 1'b1);
    cycle();
    chk("t4_discard_done", o_busy, 1'b0);
    chk("t4_refetch", o_fire, 1'b1);
    chk("t4_refetch_addr", o_addr, 32'h100);
    found = 1'b0; first_pc = 32'd0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (o_idv && !found) begin found = 1'b1; first_pc = o_pc; end
    end
    chk("t4_first_pc", first_pc, 32'h100);

    // halt with two outstanding
    mem_lat = 2;
    do_reset(6);
    repeat (6) cycle();
    halt = 1'b1; fires = 0; lastpc = 32'hFFFF_FFFF;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (o_fire) fires++;
      if (o_idv) lastpc = o_pc;
    end
    chk("t5_no_req", 32'(fires), 32'd0);
    chk("t5_busy_idle", o_busy, 1'b0);
    chk("t5_last_pc", lastpc, 32'd5);
    halt = 1'b0; found = 1'b0; first_addr = 32'd0;
    for (int k = 0; k < 10 && !found; k++) begin
      cycle();
      if (o_fire) begin found = 1'b1; first_addr = o_addr; end
    end
    chk("t5_resume_found", found, 1'b1);
    chk("t5_resume_addr", first_addr, 32'd6);

    // reset mid-operation, stale responses afterwards
    mem_lat = 3; id_ready = 1'b0;
    do_reset(6);
    repeat (5) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0; halt = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("t6_idv", o_idv, 1'b0);
      chk("t6_busy", o_busy, 1'b0);
    end
    halt = 1'b0; id_ready = 1'b1; mem_lat = 1;
    found = 1'b0; found2 = 1'b0; first_addr = 32'hFFFF_FFFF; first_pc = 32'hFFFF_FFFF; first_instr = 32'd0;
    for (int k = 0; k < 12; k++) begin
      cycle();
      if (o_fire && !found) begin found = 1'b1; first_addr = o_addr; end
      if (o_idv && !found2) begin found2 = 1'b1; first_pc = o_pc; first_instr = o_instr; end
    end
    chk("t6_first_addr", first_addr, 32'd0);
    chk("t6_first_pc", first_pc, 32'd0);
    chk("t6_first_instr", first_instr, 32'h13);

    // randomized traffic
    do_reset(6);
    for (int k = 0; k < 600; k++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      id_ready       = ($urandom_range(0, 3) != 0);
      mem_lat        = $urandom_range(1, 4);
      if ($urandom_range(0, 19) == 0) halt = !halt;
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom;
      cycle();
    end
    halt = 1'b0; redirect_valid = 1'b0; imem_req_ready = 1'b1; id_ready = 1'b1;
    repeat (30) cycle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end
endmodule
